// File: rtl/pulse_stretcher_mc.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher_mc
// Purpose  : Multi-channel pulse widener. Each of N_CH independent channels
//            turns a trigger on sig_i[c] into a sig_o[c] pulse lasting
//            width_i cycles. width_i is sampled when the trigger is accepted,
//            and a width of 0 is treated as 1. Edge or level triggering and
//            retrigger or one-shot behaviour are chosen by parameter.
//            Triggers that the channel ignores set a sticky miss flag.
// Ports    : clk      - sole clock, rising edge
//            rst_n    - synchronous active-low reset
//            sig_i    - [N_CH]  trigger inputs
//            width_i  - [CNT_W] pulse length, shared by all channels
//            clr_i    - clears every miss_o bit
//            sig_o    - [N_CH]  stretched pulses
//            busy_o   - [N_CH]  channel not idle
//            miss_o   - [N_CH]  sticky dropped-trigger flags
// Options  : Macro PULSE_HOLDOFF_EN adds a HOLD state. After each pulse the
//            channel stays busy and ignores triggers for HOLDOFF cycles.
//            Without the macro the HOLDOFF parameter is unused.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher_mc #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int EDGE    = 1,
    parameter int RETRIG  = 0,
    parameter int HOLDOFF = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sig_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic             clr_i,
    output logic [N_CH-1:0]  sig_o,
    output logic [N_CH-1:0]  busy_o,
    output logic [N_CH-1:0]  miss_o
);

`ifdef PULSE_HOLDOFF_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter preload for the hold-off phase. It is only used when HOLDOFF > 0.
    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLDOFF - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1
    } state_t;

    logic w_unused_holdoff;
    assign w_unused_holdoff = (HOLDOFF != 0);
`endif

    logic [N_CH-1:0]  w_trig;
    logic [CNT_W-1:0] w_load;

    // Counter load value W-1, with a zero width treated as a width of 1.
    assign w_load = (width_i == '0) ? '0 : (width_i - CNT_W'(1));

    // ------------------------------------------------------------------
    // Trigger qualification
    // ------------------------------------------------------------------
    generate
        if (EDGE != 0) begin : g_edge
            logic [N_CH-1:0] prev_q;
            logic [N_CH-1:0] prev_d;

            // prev resets to 0. An input that is already high when reset is
            // released therefore counts as a rising edge.
            assign prev_d = sig_i;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= prev_d;
                end
            end

            assign w_trig = sig_i & ~prev_q;
        end else begin : g_level
            assign w_trig = sig_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-channel FSM, counter and miss flag
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             miss_q;
            logic             miss_d;
            logic             w_drop;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                w_drop  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (w_trig[c]) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = w_load;
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_trig[c] && (RETRIG != 0)) begin
                            cnt_d = w_load;
                        end else if (cnt_q == '0) begin
`ifdef PULSE_HOLDOFF_EN
                            if (HOLDOFF == 0) begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_HOLD;
                                cnt_d   = c_hold_load;
                            end
`else
                            state_d = ST_IDLE;
                            cnt_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                        // In one-shot mode, a trigger during the pulse
                        // (including its final cycle) is lost.
                        if (w_trig[c] && (RETRIG == 0)) begin
                            w_drop = 1'b1;
                        end
                    end
`ifdef PULSE_HOLDOFF_EN
                    ST_HOLD: begin
                        w_drop = w_trig[c];
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // If a trigger is dropped in the same cycle as clr_i, the flag
            // is set.
            always_comb begin
                miss_d = miss_q;
                if (w_drop) begin
                    miss_d = 1'b1;
                end else if (clr_i) begin
                    miss_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    miss_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    miss_q  <= miss_d;
                end
            end

            assign sig_o[c]  = (state_q == ST_ACTIVE);
            assign busy_o[c] = (state_q != ST_IDLE);
            assign miss_o[c] = miss_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher_mc
// Purpose  : Self-checking bench for pulse_stretcher_mc. It runs three
//            instances in parallel:
//              inst 0 - edge-triggered, one-shot
//              inst 1 - edge-triggered, retriggerable
//              inst 2 - level-triggered, one-shot
//            A reference model records the cycle at which each pulse ends and
//            the cycle at which each busy period ends. On every clock the
//            expected outputs are queued and then compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher_mc;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 16;
    localparam int N_INST = 3;
    localparam int HOLD_P = 3;
`ifdef PULSE_HOLDOFF_EN
    localparam int HOLD_EFF = HOLD_P;
`else
    localparam int HOLD_EFF = 0;
`endif

    typedef struct {
        logic [N_CH-1:0] sig;
        logic [N_CH-1:0] busy;
        logic [N_CH-1:0] miss;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_CH-1:0]  sig_i;
    logic [CNT_W-1:0] width_i;
    logic             clr_i;
    logic [N_CH-1:0]  so [N_INST];
    logic [N_CH-1:0]  bo [N_INST];
    logic [N_CH-1:0]  mo [N_INST];

    int   n_checks = 0;
    int   n_err    = 0;
    int   t        = 0;
    exp_t sb[$];

    // Per-instance model state
    int   edge_p   [N_INST] = '{1, 1, 0};
    int   retrig_p [N_INST] = '{0, 1, 0};
    int   act_end  [N_INST][N_CH];
    int   busy_end [N_INST][N_CH];
    bit   prev_m   [N_INST][N_CH];
    bit   miss_m   [N_INST][N_CH];

    always #5 clk = ~clk;

    pulse_stretcher_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .EDGE(1), .RETRIG(0), .HOLDOFF(HOLD_P)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .width_i(width_i), .clr_i(clr_i),
        .sig_o(so[0]), .busy_o(bo[0]), .miss_o(mo[0]));
    pulse_stretcher_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .EDGE(1), .RETRIG(1), .HOLDOFF(HOLD_P)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .width_i(width_i), .clr_i(clr_i),
        .sig_o(so[1]), .busy_o(bo[1]), .miss_o(mo[1]));
    pulse_stretcher_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .EDGE(0), .RETRIG(0), .HOLDOFF(HOLD_P)) dut_c (
        .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .width_i(width_i), .clr_i(clr_i),
        .sig_o(so[2]), .busy_o(bo[2]), .miss_o(mo[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model over the coming rising edge, using the inputs that
    // are currently applied, and queue the outputs expected after that edge.
    task automatic model_edge();
        for (int i = 0; i < N_INST; i++) begin
            exp_t e;
            for (int c = 0; c < N_CH; c++) begin
                if (!rst_n) begin
                    act_end[i][c]  = t;
                    busy_end[i][c] = t;
                    prev_m[i][c]   = 1'b0;
                    miss_m[i][c]   = 1'b0;
                end else begin
                    bit trg;
                    bit drop;
                    int w;
                    trg  = (edge_p[i] != 0) ? (sig_i[c] & ~prev_m[i][c]) : sig_i[c];
                    drop = 1'b0;
                    w    = (width_i == 0) ? 1 : int'(width_i);
                    if (trg) begin
                        if (t > busy_end[i][c]) begin
                            act_end[i][c]  = t + w;
                            busy_end[i][c] = t + w + HOLD_EFF;
                        end else if (t <= act_end[i][c] && retrig_p[i] != 0) begin
                            act_end[i][c]  = t + w;
                            busy_end[i][c] = t + w + HOLD_EFF;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    if (drop)       miss_m[i][c] = 1'b1;
                    else if (clr_i) miss_m[i][c] = 1'b0;
                    prev_m[i][c] = sig_i[c];
                end
                e.sig[c]  = (t < act_end[i][c]);
                e.busy[c] = (t < busy_end[i][c]);
                e.miss[c] = miss_m[i][c];
            end
            sb.push_back(e);
        end
        t++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_INST; i++) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("sig_o i%0d t%0d", i, t - 1), 32'(so[i]), 32'(e.sig));
            check($sformatf("busy_o i%0d t%0d", i, t - 1), 32'(bo[i]), 32'(e.busy));
            check($sformatf("miss_o i%0d t%0d", i, t - 1), 32'(mo[i]), 32'(e.miss));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Drive sig_i for one cycle, then return it to 0.
    task automatic pulse(input logic [N_CH-1:0] v);
        sig_i = v;
        step();
        sig_i = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        sig_i   = '0;
        width_i = 16'd5;
        clr_i   = 1'b0;
        idle(3);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("reset outputs i%0d", i), 32'({so[i], bo[i], mo[i]}), 32'd0);
        end
        rst_n = 1'b1;

        // Basic single-cycle trigger, W=5
        idle(9);
        pulse(4'b0001);
        idle(8);

        // Zero width acts as one cycle
        width_i = 16'd0;
        pulse(4'b0010);
        idle(4);

        // A second edge during the pulse, then clear the miss flags
        width_i = 16'd8;
        pulse(4'b0100);
        idle(3);
        pulse(4'b0100);
        idle(12);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        idle(2);

        // Trigger on the final active cycle
        pulse(4'b0100);
        idle(7);
        pulse(4'b0100);
        idle(20);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;

        // Level held high, then reset in the middle of a pulse
        width_i = 16'd4;
        sig_i   = 4'b1000;
        idle(30);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(3);
        sig_i = '0;
        idle(6);

        // Hold-off pattern: W=2, then triggers 3 and 6 cycles later
        width_i = 16'd2;
        pulse(4'b0001);
        idle(2);
        pulse(4'b0001);
        idle(2);
        pulse(4'b0001);
        idle(10);

        // Random traffic, including width changes during pulses
        for (int k = 0; k < 300; k++) begin
            sig_i   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            width_i = 16'($urandom_range(0, 6));
            clr_i   = ($urandom_range(0, 9) == 0);
            rst_n   = ($urandom_range(0, 79) != 0);
            step();
        end
        rst_n = 1'b1;
        clr_i = 1'b0;
        sig_i = '0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_stretcher_mc.md
# pulse_stretcher_mc

Multi-channel, parametrised pulse widener. Each of `N_CH` independent channels converts a trigger on its input bit into an output pulse of programmable length. Options: edge or level triggering, retriggerable or one-shot behaviour, per-channel missed-trigger flags, and an optional post-pulse hold-off. The block sits between the detection logic and the indicator/actuator outputs of the harness, running on the slow harness clock.

## Interface
- `N_CH`, 4: number of independent channels.
- `CNT_W`, 16: width of pulse-length input and per-channel counters.
- `EDGE`, 1: 1 = trigger on rising edge of `sig_i[c]`; 0 = trigger whenever `sig_i[c]` is high.
- `RETRIG`, 0: 1 = trigger during active pulse reloads counter; 0 = ignored.
- `HOLDOFF`, 15: hold-off length in cycles. Used only with `PULSE_HOLDOFF_EN`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sig_i`  in  N_CH  trigger inputs, synchronous to `clk`.
- `width_i`  in  CNT_W  pulse length in cycles, shared by all channels, sampled per channel at its trigger.
- `clr_i`  in  1  synchronous clear of all `miss_o` bits.
- `sig_o`  out  N_CH  stretched pulses.
- `busy_o`  out  N_CH  channel not IDLE (ACTIVE or HOLD).
- `miss_o`  out  N_CH  sticky: a trigger was ignored on that channel.

## Operation
- Per-channel trigger qualification:
  - `EDGE=1`: `trig = sig_i[c] & ~prev[c]`, where `prev` is registered `sig_i`.
  - `EDGE=0`: `trig = sig_i[c]`.
- Per-channel FSM states: IDLE, ACTIVE, HOLD (HOLD exists only with macro).
- Effective width `W = (width_i == 0) ? 1 : width_i`.
- IDLE:
  - On `trig`, load `cnt <= W-1` and go to ACTIVE.
  - Otherwise stay; `cnt` held at 0.
- ACTIVE: `sig_o[c]=1`.
  - If `trig` and `RETRIG=1`: `cnt <= W-1` using the current `width_i`; stay.
  - Else if `cnt == 0`: go to IDLE (or HOLD with macro, loading `cnt <= HOLDOFF-1`; if `HOLDOFF == 0`, go to IDLE).
  - Else decrement `cnt`.
  - If `trig` and `RETRIG=0`: trigger dropped; set `miss_o[c]`.
- HOLD: `sig_o[c]=0`, `busy_o[c]=1`.
  - Decrement `cnt`; go to IDLE when `cnt == 0`.
  - Any `trig` is dropped and sets `miss_o[c]`.
- `miss_o[c]`:
  - Set by a dropped trigger; cleared by `clr_i`.
  - Set wins over clear in the same cycle.
- Channels are fully independent; no arbitration.
- Counter arithmetic is unsigned `CNT_W`-bit. No wrap can occur, because decrement happens only when `cnt != 0`.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - all states IDLE; `cnt`, `prev`, `sig_o`, `busy_o`, `miss_o` all 0.
  - Reset mid-pulse truncates the pulse at the next edge.
- Latency: trigger sampled at edge k → `sig_o[c]` high from just after edge k, for exactly W cycles (edges k+1 … k+W see it high).
- `busy_o` rises with `sig_o`. Without macro it falls with `sig_o`; with macro it falls HOLDOFF cycles later.
- Simultaneous trigger on the final ACTIVE cycle (`cnt == 0`):
  - `RETRIG=1`: reload; the pulse is seamless (W more cycles).
  - `RETRIG=0`: pulse ends; trigger dropped; `miss_o` set.
- `EDGE=0` with `sig_i` held high, `RETRIG=0`, no macro: pulses of W cycles separated by a 1-cycle low gap. `miss_o` sets during the pulse.
- `sig_i` high at reset release with `EDGE=1`: counts as a rising edge (`prev` resets to 0).
- A `width_i` change affects only subsequent loads.

## Configuration
- `PULSE_HOLDOFF_EN`:
  - Defined: HOLD state is compiled in. After each pulse the channel ignores triggers for HOLDOFF cycles and flags them in `miss_o`.
  - Undefined: no HOLD state and `HOLDOFF` is unused. ACTIVE returns directly to IDLE, and the channel can retrigger on the very next edge.

## Test plan
- Reset with `sig_i=4'b0000`, `width_i=5`: all outputs 0. Single-cycle pulse on `sig_i[0]` at edge 10 → `sig_o[0]` high for edges 11–15, other channels 0, `miss_o=0`.
- `width_i=0`, trigger ch1 → `sig_o[1]` high exactly 1 cycle.
- `RETRIG=0`, W=8: second edge on ch2 at cycle 4 of the pulse → pulse still 8 cycles, `miss_o[2]=1`; `clr_i` pulse → `miss_o[2]=0`.
- `RETRIG=1`, W=8: second edge at cycle 4 → total high time 12 cycles. Edge on the last cycle → 16 contiguous cycles.
- `EDGE=0`, `sig_i[3]` held high 30 cycles, W=4 → repeating pattern of 4 high, 1 low. Reset asserted mid-pulse → `sig_o=0` the next cycle.
- With `PULSE_HOLDOFF_EN`, `HOLDOFF=3`, W=2:
  - trigger at edge 10 → `sig_o` high for edges 11–12; `busy_o` high for edges 11–15.
  - a trigger at edge 13 is dropped and sets `miss`.
  - a trigger at edge 16 starts a new pulse.
